// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limit, scan FSM states and the nibble decode function.
package bcd_pkg;

    localparam int BCD_MAX = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] onehot;
        logic       err;
    } dec_t;

    // Codes above BCD_MAX produce no one-hot bit and flag err instead.
    function automatic dec_t bcd_decode(input logic [3:0] nib);
        dec_t d;
        d.onehot = '0;
        for (int k = 0; k <= BCD_MAX; k++) begin
            d.onehot[k] = (nib == 4'(k));
        end
        d.err = (nib > 4'(BCD_MAX));
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational nibble -> decimal one-hot plus non-BCD flag; zero latency, no flow control.
module bcd_digit_decode
    import bcd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [9:0] onehot,
    output logic       err
);

    dec_t dec;

    always_comb begin
        dec    = bcd_decode(nib);
        onehot = dec.onehot;
        err    = dec.err;
    end

endmodule

// File: rtl/bcd_scan_decoder.sv
// Latches a packed BCD word and emits one decoded digit per beat, LSB nibble first; first beat 1 cycle after accept.
// Beats hold under out_ready low; a one-cycle idle bubble follows the last beat before the next word is taken.
module bcd_scan_decoder
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [9:0]            out_onehot,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_last,
    output logic                  out_err,
    output logic                  out_word_err
);

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   word_q, word_d;

    logic                  scanning;
    logic                  last_beat;
    logic                  accept;
    logic                  beat_done;
    logic [3:0]            cur_nib;
    logic [9:0]            dec_onehot;
    logic                  dec_err;
    logic                  word_err;

    assign scanning  = (state_q == SCAN);
    assign last_beat = (idx_q == IDXW'(DIGITS - 1));
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign beat_done = scanning && out_ready;

    // Explicit compare-select keeps non-power-of-two DIGITS from indexing past the word.
    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_nib = word_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        word_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            word_err = word_err | (word_q[4*i +: 4] > 4'(BCD_MAX));
        end
    end

    bcd_digit_decode u_dec (
        .nib    (cur_nib),
        .onehot (dec_onehot),
        .err    (dec_err)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = in_bcd;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (beat_done) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    // All beat fields read as zero whenever no beat is presented.
    always_comb begin
        out_valid    = scanning;
        out_onehot   = scanning ? dec_onehot : 10'h000;
        out_idx      = scanning ? idx_q      : '0;
        out_last     = scanning && last_beat;
        out_err      = scanning && dec_err;
        out_word_err = scanning && word_err;
    end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
module tb_bcd_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_onehot;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_err;
    logic        out_word_err;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  in_bcd1;
    logic        out_valid1;
    logic        out_ready1;
    logic [9:0]  out_onehot1;
    logic [0:0]  out_idx1;
    logic        out_last1;
    logic        out_err1;
    logic        out_word_err1;

    int n_cmp;
    int n_bad;

    bcd_scan_decoder #(.DIGITS(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bcd       (in_bcd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_onehot   (out_onehot),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_err      (out_err),
        .out_word_err (out_word_err)
    );

    bcd_scan_decoder #(.DIGITS(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .in_bcd       (in_bcd1),
        .out_valid    (out_valid1),
        .out_ready    (out_ready1),
        .out_onehot   (out_onehot1),
        .out_idx      (out_idx1),
        .out_last     (out_last1),
        .out_err      (out_err1),
        .out_word_err (out_word_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat vector layout: {valid, onehot[9:0], idx[1:0], last, err, word_err}
    task automatic test_reset();
        logic [15:0] obs;
        repeat (2) @(negedge clk);
        obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0000", obs);
        end
        n_cmp++;
        if ({in_ready, in_ready1, out_valid1} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 000", {in_ready, in_ready1, out_valid1});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: ready/valid got %b want 10", {in_ready, out_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [9:0]  exp_oh [4] = '{10'h010, 10'h008, 10'h004, 10'h002};
        logic [15:0] obs, exp;
        in_bcd = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
            exp = {1'b1, exp_oh[k], 2'(k), (k == 3), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got %h want %h", k, obs, exp);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_idle: valid/ready got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_error();
        logic [9:0]  exp_oh [4] = '{10'h020, 10'h001, 10'h000, 10'h200};
        logic        exp_er [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] obs, exp;
        in_bcd = 16'h9A05; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
            exp = {1'b1, exp_oh[k], 2'(k), (k == 3), exp_er[k], 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL error_beat%0d: got %h want %h", k, obs, exp);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({out_valid, out_word_err, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL error_idle: got %b want 001", {out_valid, out_word_err, in_ready});
        end
    endtask

    task automatic test_stall();
        logic [15:0] obs, exp;
        in_bcd = 16'h5678; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
        exp = {1'b1, 10'h100, 2'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL stall_beat0: got %h want %h", obs, exp);
        end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_bcd = 16'h1111;
        exp = {1'b1, 10'h080, 2'd1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got %h want %h", c, obs, exp);
            end
            if (c < 3) @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
        exp = {1'b1, 10'h040, 2'd2, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL stall_beat2: got %h want %h", obs, exp);
        end
        @(negedge clk);
        obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
        exp = {1'b1, 10'h020, 2'd3, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL stall_beat3: got %h want %h", obs, exp);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL stall_idle: valid/ready got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs, exp;
        in_bcd = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_idx} !== 3'b110) begin
            n_bad++;
            $display("FAIL midrst_pre: valid/idx got %b want 110", {out_valid, out_idx});
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
        n_cmp++;
        if ({in_ready, obs} !== 17'h0) begin
            n_bad++;
            $display("FAIL midrst_async: got %h want 00000", {in_ready, obs});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_release: ready/valid got %b want 10", {in_ready, out_valid});
        end
        in_bcd = 16'h0009; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = {out_valid, out_onehot, out_idx, out_last, out_err, out_word_err};
            exp = {1'b1, (k == 0) ? 10'h200 : 10'h001, 2'(k), (k == 3), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midrst_beat%0d: got %h want %h", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_digits1();
        logic [14:0] obs;
        in_bcd1 = 4'h7; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        obs = {out_valid1, out_onehot1, out_idx1, out_last1, out_err1, out_word_err1};
        n_cmp++;
        if (obs !== {1'b1, 10'h080, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL d1_beat: got %h want %h", obs, {1'b1, 10'h080, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            n_bad++;
            $display("FAIL d1_idle: valid/ready got %b want 01", {out_valid1, in_ready1});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        logic       v;
        in_bcd = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            v   = ((k % 5) != 4);
            exp = {v, !v, v ? 2'(k % 5) : 2'd0};
            obs = {out_valid, in_ready, out_idx};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d: valid/ready/idx got %b want %b", k, obs, exp);
            end
            if (k == 9) in_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_end: valid/ready got %b want 01", {out_valid, in_ready});
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bcd     = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_bcd1    = '0;
        out_ready1 = 1'b0;
        test_reset();
        test_basic();
        test_error();
        test_stall();
        test_reset_mid();
        test_digits1();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
